// File: rtl/lt24_pixel_sink.sv
// rtl/lt24_pixel_sink.sv - pixel-write responder driving LT24 8080-style bus cycles; optional address prediction under LT24_PIXEL_SINK_CACHE_EN
module lt24_pixel_sink #(
    parameter int WIDTH     = 240,
    parameter int HEIGHT    = 320,
    parameter int WR_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        outOfRange,
    output logic        LT24CS_n,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STROBE_LOW  = 2'd1,
        STROBE_HIGH = 2'd2,
        DROP        = 2'd3
    } state_t;

    localparam int          PW         = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(WR_CYCLES - 1);
    localparam logic [15:0] W16        = 16'(WIDTH);
    localparam logic [15:0] H16        = 16'(HEIGHT);
    localparam logic [15:0] WIDTH_M1   = 16'(WIDTH - 1);
    localparam logic [15:0] HEIGHT_M1  = 16'(HEIGHT - 1);
    localparam logic [3:0]  LAST_WORD  = 4'd11;

    state_t        state_q, state_d;
    logic [3:0]    word_q, word_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [15:0]   pix_q, pix_d;
    logic          armed_q;
    logic          ready_q, oor_q, cs_n_q, wr_n_q, rs_q;
    logic [15:0]   data_q;
    logic          accept, in_range, cache_hit, seq_done;

    assign accept   = pixelWrite && ready_q && armed_q;
    assign in_range = (16'(xAddr) < W16) && (16'(yAddr) < H16);
    assign seq_done = (state_q == STROBE_HIGH) && (phase_q == PHASE_LAST) && (word_q == LAST_WORD);

    // {RS, word} for each slot of the 12-word CASET/PASET/RAMWR sequence
    function automatic logic [16:0] word_mux(input logic [3:0] w, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] p);
        case (w)
            4'd0:    word_mux = {1'b0, 16'h002A};
            4'd1:    word_mux = {1'b1, 16'h0000};
            4'd2:    word_mux = {1'b1, 8'h00, x};
            4'd3:    word_mux = {1'b1, 8'h00, WIDTH_M1[15:8]};
            4'd4:    word_mux = {1'b1, 8'h00, WIDTH_M1[7:0]};
            4'd5:    word_mux = {1'b0, 16'h002B};
            4'd6:    word_mux = {1'b1, 15'h0000, y[8]};
            4'd7:    word_mux = {1'b1, 8'h00, y[7:0]};
            4'd8:    word_mux = {1'b1, 8'h00, HEIGHT_M1[15:8]};
            4'd9:    word_mux = {1'b1, 8'h00, HEIGHT_M1[7:0]};
            4'd10:   word_mux = {1'b0, 16'h002C};
            default: word_mux = {1'b1, p};
        endcase
    endfunction

`ifdef LT24_PIXEL_SINK_CACHE_EN
    logic [8:0] pred_x_q;
    logic [8:0] pred_y_q;
    logic       pred_valid_q;

    assign cache_hit = pred_valid_q && ({1'b0, xAddr} == pred_x_q) && (yAddr == pred_y_q);

    // Predict the auto-incremented address after each completed sequence; any other accept kills it
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_x_q     <= '0;
            pred_y_q     <= '0;
            pred_valid_q <= 1'b0;
        end else if (accept && !cache_hit) begin
            pred_valid_q <= 1'b0;
        end else if (seq_done) begin
            pred_x_q     <= {1'b0, x_q} + 9'd1;
            pred_y_q     <= y_q;
            pred_valid_q <= (16'(x_q) + 16'd1) < W16;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Next-state: word index and phase counter walk the strobe sequence
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = xAddr;
                    y_d     = yAddr;
                    pix_d   = pixelData;
                    phase_d = '0;
                    if (!in_range) begin
                        state_d = DROP;
                    end else begin
                        state_d = STROBE_LOW;
                        word_d  = cache_hit ? LAST_WORD : 4'd0;
                    end
                end
            end
            STROBE_LOW: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    state_d = STROBE_HIGH;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            STROBE_HIGH: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (word_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + 4'd1;
                        state_d = STROBE_LOW;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered pin outputs derived from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            ready_q <= 1'b0;
            oor_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            ready_q <= (state_d == IDLE);
            oor_q   <= (state_d == DROP);
            cs_n_q  <= !((state_d == STROBE_LOW) || (state_d == STROBE_HIGH));
            wr_n_q  <= (state_d != STROBE_LOW);
            // Bus word only moves at a word boundary, so it holds across both phases
            if (state_d == STROBE_LOW) begin
                {rs_q, data_q} <= word_mux(word_d, x_d, y_d, pix_d);
            end
        end
    end

    // One write per request: re-armed only once the drawer drops pixelWrite
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (accept) begin
            armed_q <= 1'b0;
        end else if (!pixelWrite) begin
            armed_q <= 1'b1;
        end
    end

    assign pixelReady = ready_q;
    assign outOfRange = oor_q;
    assign LT24CS_n   = cs_n_q;
    assign LT24Wr_n   = wr_n_q;
    assign LT24Rd_n   = 1'b1;
    assign LT24RS     = rs_q;
    assign LT24Data   = data_q;

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// tb/tb_lt24_pixel_sink.sv - directed self-checking bench for lt24_pixel_sink
module tb_lt24_pixel_sink;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady, outOfRange, LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS;
    logic [15:0] LT24Data;

    int checks = 0;
    int errors = 0;

    logic [16:0] words[$];
    logic [16:0] fall_word = '0;
    logic        prev_wr = 1'b1;
    int          cs_err = 0;
    int          stab_err = 0;

    lt24_pixel_sink #(.WIDTH(240), .HEIGHT(320), .WR_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .outOfRange(outOfRange), .LT24CS_n(LT24CS_n), .LT24Wr_n(LT24Wr_n),
        .LT24Rd_n(LT24Rd_n), .LT24RS(LT24RS), .LT24Data(LT24Data)
    );

    always #5 clock = ~clock;

    // Bus monitor: capture a word at each Wr_n fall, confirm it is unchanged at the rise
    always @(negedge clock) begin
        if (prev_wr && !LT24Wr_n) begin
            words.push_back({LT24RS, LT24Data});
            fall_word = {LT24RS, LT24Data};
            if (LT24CS_n !== 1'b0) cs_err++;
        end
        if (!prev_wr && LT24Wr_n && !reset) begin
            if (({LT24RS, LT24Data} !== fall_word) || (LT24CS_n !== 1'b0)) stab_err++;
        end
        prev_wr = LT24Wr_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  busy;
    logic oor_first;
    logic cs_at_exit;

    task automatic write_px(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        @(negedge clock);
        pixelWrite = 1'b0;
        words.delete();
        @(negedge clock);
        xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1;
        busy = 0;
        oor_first = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #1;
            if (i == 0) oor_first = outOfRange;
            if (pixelReady) break;
            busy++;
        end
        cs_at_exit = LT24CS_n;
        pixelWrite = 1'b0;
    endtask

    logic [16:0] exp1 [12];
    int seen;

    initial begin
        exp1 = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h100EF, 17'h0002B,
                 17'h10000, 17'h10014, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", pixelReady, 1'b0);
        check("rst_oor", outOfRange, 1'b0);
        check("rst_cs_n", LT24CS_n, 1'b1);
        check("rst_wr_n", LT24Wr_n, 1'b1);
        check("rst_rd_n", LT24Rd_n, 1'b1);
        check("rst_rs", LT24RS, 1'b1);
        check("rst_data", LT24Data, 16'h0000);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", pixelReady, 1'b1);

        // Full sequence for (10,20,F800)
        write_px(8'd10, 9'd20, 16'hF800);
        check("w1_busy", busy, 48);
        check("w1_count", words.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("w1_word%0d", i), words[i], exp1[i]);
        check("w1_cs_rise_with_ready", cs_at_exit, 1'b1);
        check("w1_oor", oor_first, 1'b0);

        // Sequential next pixel (11,20)
        write_px(8'd11, 9'd20, 16'h001F);
`ifdef LT24_PIXEL_SINK_CACHE_EN
        check("w2_busy", busy, 4);
        check("w2_count", words.size(), 1);
        check("w2_word", words[0], 17'h1001F);
`else
        check("w2_busy", busy, 48);
        check("w2_count", words.size(), 12);
        check("w2_x", words[2], 17'h1000B);
        check("w2_pix", words[11], 17'h1001F);
`endif

        // Last column, then out of range, then new line
        write_px(8'd239, 9'd5, 16'h07E0);
        check("w3_busy", busy, 48);
        check("w3_x", words[2], 17'h100EF);
        check("w3_y", words[7], 17'h10005);
        write_px(8'd240, 9'd5, 16'h1234);
        check("w4_busy", busy, 1);
        check("w4_oor", oor_first, 1'b1);
        check("w4_count", words.size(), 0);
        @(negedge clock);
        check("w4_oor_clear", outOfRange, 1'b0);
        write_px(8'd0, 9'd6, 16'h5555);
        check("w5_busy", busy, 48);
        check("w5_count", words.size(), 12);
        check("w5_y", words[7], 17'h10006);

        // Y out of range is dropped as well
        write_px(8'd3, 9'd320, 16'hAAAA);
        check("w6_busy", busy, 1);
        check("w6_oor", oor_first, 1'b1);
        check("w6_count", words.size(), 0);

        // Held request yields one sequence; re-arming yields exactly one more
        @(negedge clock);
        pixelWrite = 1'b0;
        @(negedge clock);
        words.delete();
        xAddr = 8'd1; yAddr = 9'd1; pixelData = 16'h0F0F; pixelWrite = 1'b1;
        repeat (200) @(negedge clock);
        check("hold_count", words.size(), 12);
        pixelWrite = 1'b0;
        @(negedge clock);
        words.delete();
        pixelWrite = 1'b1;
        repeat (100) @(negedge clock);
        check("rearm_count", words.size(), 12);
        pixelWrite = 1'b0;

        // Reset during word 5
        @(negedge clock);
        words.delete();
        xAddr = 8'd50; yAddr = 9'd60; pixelData = 16'h3333; pixelWrite = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (words.size() == 5) begin
                seen = 1;
                break;
            end
        end
        check("mid_reached_word5", seen, 1);
        reset = 1'b1;
        pixelWrite = 1'b0;
        @(negedge clock);
        check("mid_wr_n", LT24Wr_n, 1'b1);
        check("mid_cs_n", LT24CS_n, 1'b1);
        check("mid_ready", pixelReady, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("mid_no_more_words", words.size(), 5);
        write_px(8'd2, 9'd1, 16'h7777);
        check("post_rst_busy", busy, 48);
        check("post_rst_count", words.size(), 12);

        check("cs_low_all_words", cs_err, 0);
        check("word_stable", stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
